// File: rtl/ysyx_bus_pkg.sv
// Shared bus definitions for the core-to-AXI arbiter: FSM state encodings,
// AXI4 burst/response codes and the requester IDs carried on AXI.
package ysyx_bus_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [3:0] AXI_ID_IFU     = 4'd0;
   localparam logic [3:0] AXI_ID_LSU     = 4'd1;

   // Any non-OKAY response (EXOKAY included) is reported as an error to the core.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp != AXI_RESP_OKAY);
   endfunction

endpackage

// File: rtl/ysyx_axi_arbiter_if.sv
// Core-side request/response ports plus the AXI4 master channels of the arbiter.
// The master modport is the arbiter's view; slave is the core/memory environment.
interface ysyx_axi_arbiter_if #(parameter int XLEN = 32);
   logic            ifu_req_valid;
   logic [XLEN-1:0] ifu_req_addr;
   logic            ifu_req_ready;
   logic            ifu_rsp_valid;
   logic [XLEN-1:0] ifu_rsp_data;
   logic            ifu_rsp_err;

   logic            lsu_rd_valid;
   logic [XLEN-1:0] lsu_rd_addr;
   logic [2:0]      lsu_rd_size;
   logic            lsu_rd_ready;
   logic            lsu_rd_rsp_valid;
   logic [XLEN-1:0] lsu_rd_rsp_data;
   logic            lsu_rd_rsp_err;

   logic            lsu_wr_valid;
   logic [XLEN-1:0] lsu_wr_addr;
   logic [XLEN-1:0] lsu_wr_data;
   logic [3:0]      lsu_wr_strb;
   logic [2:0]      lsu_wr_size;
   logic            lsu_wr_ready;
   logic            lsu_wr_done;
   logic            lsu_wr_err;

   logic            awvalid, awready;
   logic [3:0]      awid;
   logic [XLEN-1:0] awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            wvalid, wready, wlast;
   logic [XLEN-1:0] wdata;
   logic [3:0]      wstrb;
   logic            bvalid, bready;
   logic [3:0]      bid;
   logic [1:0]      bresp;
   logic            arvalid, arready;
   logic [3:0]      arid;
   logic [XLEN-1:0] araddr;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic            rvalid, rready, rlast;
   logic [3:0]      rid;
   logic [XLEN-1:0] rdata;
   logic [1:0]      rresp;

   modport master (
      input  ifu_req_valid, ifu_req_addr,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
      input  lsu_rd_valid, lsu_rd_addr, lsu_rd_size,
      output lsu_rd_ready, lsu_rd_rsp_valid, lsu_rd_rsp_data, lsu_rd_rsp_err,
      input  lsu_wr_valid, lsu_wr_addr, lsu_wr_data, lsu_wr_strb, lsu_wr_size,
      output lsu_wr_ready, lsu_wr_done, lsu_wr_err,
      output awvalid, awid, awaddr, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bresp,
      output bready,
      output arvalid, arid, araddr, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rid, rdata, rresp, rlast,
      output rready
   );

   modport slave (
      output ifu_req_valid, ifu_req_addr,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
      output lsu_rd_valid, lsu_rd_addr, lsu_rd_size,
      input  lsu_rd_ready, lsu_rd_rsp_valid, lsu_rd_rsp_data, lsu_rd_rsp_err,
      output lsu_wr_valid, lsu_wr_addr, lsu_wr_data, lsu_wr_strb, lsu_wr_size,
      input  lsu_wr_ready, lsu_wr_done, lsu_wr_err,
      input  awvalid, awid, awaddr, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bresp,
      input  bready,
      input  arvalid, arid, araddr, arlen, arsize, arburst,
      output arready,
      output rvalid, rid, rdata, rresp, rlast,
      input  rready
   );
endinterface

// File: rtl/ysyx_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, last winner loses the next tie.
// Reset leaves requester 1 as last winner so requester 0 takes the first tie.
module ysyx_rr_arb2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic [1:0] o_gnt
);
   logic r_last;

   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_last <= 1'b1;
      end else if (i_take && (o_gnt != 2'b00)) begin
         r_last <= o_gnt[1];
      end else begin
         r_last <= r_last;
      end
   end
endmodule

// File: rtl/ysyx_axi_arbiter.sv
// Shares one AXI4 master between IFU fetches, LSU loads and LSU stores.
// Reads and writes run as independent single-beat FSMs; one read outstanding.
module ysyx_axi_arbiter
   import ysyx_bus_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                clock,
   input  logic                reset,
   ysyx_axi_arbiter_if.master  bus
);
   rd_state_e       r_rd_state, w_rd_next;
   logic            r_rd_lsu;
   logic [XLEN-1:0] r_rd_addr;
   logic [2:0]      r_rd_size;
   logic [1:0]      w_rd_req, w_rd_gnt;
   logic            w_rd_take;

   wr_state_e       r_wr_state, w_wr_next;
   logic [XLEN-1:0] r_wr_addr, r_wr_data;
   logic [3:0]      r_wr_strb;
   logic [2:0]      r_wr_size;
   logic            r_aw_pend, r_w_pend;
   logic            w_wr_take;
   logic            w_unused;

   assign w_rd_req = {bus.lsu_rd_valid, bus.ifu_req_valid};
   // Routing uses the latched grant, so the AXI IDs coming back are irrelevant.
   assign w_unused = ^{bus.rid, bus.bid, bus.rlast};

   ysyx_rr_arb2 u_rr (
      .clock  (clock),
      .reset  (reset),
      .i_req  (w_rd_req),
      .i_take (w_rd_take),
      .o_gnt  (w_rd_gnt)
   );

   assign bus.araddr          = r_rd_addr;
   assign bus.arlen           = AXI_LEN_SINGLE;
   assign bus.arburst         = AXI_BURST_INCR;
   assign bus.arsize          = r_rd_size;
   assign bus.arid            = r_rd_lsu ? AXI_ID_LSU : AXI_ID_IFU;
   assign bus.ifu_rsp_data    = bus.rdata;
   assign bus.lsu_rd_rsp_data = bus.rdata;

   assign bus.awaddr  = r_wr_addr;
   assign bus.awlen   = AXI_LEN_SINGLE;
   assign bus.awburst = AXI_BURST_INCR;
   assign bus.awsize  = r_wr_size;
   assign bus.awid    = AXI_ID_LSU;
   assign bus.wdata   = r_wr_data;
   assign bus.wstrb   = r_wr_strb;
   assign bus.wlast   = 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_state <= R_IDLE;
      end else begin
         r_rd_state <= w_rd_next;
      end
   end

   // Read next-state and handshakes; every output is forced quiet during reset.
   always_comb begin
      w_rd_next            = r_rd_state;
      w_rd_take            = 1'b0;
      bus.ifu_req_ready    = 1'b0;
      bus.lsu_rd_ready     = 1'b0;
      bus.arvalid          = 1'b0;
      bus.rready           = 1'b0;
      bus.ifu_rsp_valid    = 1'b0;
      bus.ifu_rsp_err      = 1'b0;
      bus.lsu_rd_rsp_valid = 1'b0;
      bus.lsu_rd_rsp_err   = 1'b0;
      if (reset) begin
         w_rd_next = R_IDLE;
      end else begin
         case (r_rd_state)
            R_IDLE: begin
               if (w_rd_req != 2'b00) begin
                  w_rd_take         = 1'b1;
                  bus.ifu_req_ready = w_rd_gnt[0];
                  bus.lsu_rd_ready  = w_rd_gnt[1];
                  w_rd_next         = R_ADDR;
               end else begin
                  w_rd_next = R_IDLE;
               end
            end
            R_ADDR: begin
               bus.arvalid = 1'b1;
               w_rd_next   = bus.arready ? R_DATA : R_ADDR;
            end
            R_DATA: begin
               bus.rready = 1'b1;
               if (bus.rvalid) begin
                  bus.ifu_rsp_valid    = ~r_rd_lsu;
                  bus.ifu_rsp_err      = ~r_rd_lsu & resp_is_err(bus.rresp);
                  bus.lsu_rd_rsp_valid = r_rd_lsu;
                  bus.lsu_rd_rsp_err   = r_rd_lsu & resp_is_err(bus.rresp);
                  w_rd_next            = R_IDLE;
               end else begin
                  w_rd_next = R_DATA;
               end
            end
            default: w_rd_next = R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_lsu  <= 1'b0;
         r_rd_addr <= '0;
         r_rd_size <= AXI_SIZE_WORD;
      end else if (w_rd_take) begin
         r_rd_lsu  <= w_rd_gnt[1];
         r_rd_addr <= w_rd_gnt[1] ? bus.lsu_rd_addr : bus.ifu_req_addr;
         r_rd_size <= w_rd_gnt[1] ? bus.lsu_rd_size : AXI_SIZE_WORD;
      end else begin
         r_rd_lsu  <= r_rd_lsu;
         r_rd_addr <= r_rd_addr;
         r_rd_size <= r_rd_size;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_state <= W_IDLE;
      end else begin
         r_wr_state <= w_wr_next;
      end
   end

   // AW and W retire independently; leave W_ADDR once neither is still pending.
   always_comb begin
      w_wr_next        = r_wr_state;
      w_wr_take        = 1'b0;
      bus.lsu_wr_ready = 1'b0;
      bus.awvalid      = 1'b0;
      bus.wvalid       = 1'b0;
      bus.bready       = 1'b0;
      bus.lsu_wr_done  = 1'b0;
      bus.lsu_wr_err   = 1'b0;
      if (reset) begin
         w_wr_next = W_IDLE;
      end else begin
         case (r_wr_state)
            W_IDLE: begin
               if (bus.lsu_wr_valid) begin
                  w_wr_take        = 1'b1;
                  bus.lsu_wr_ready = 1'b1;
                  w_wr_next        = W_ADDR;
               end else begin
                  w_wr_next = W_IDLE;
               end
            end
            W_ADDR: begin
               bus.awvalid = r_aw_pend;
               bus.wvalid  = r_w_pend;
               if ((!r_aw_pend || bus.awready) && (!r_w_pend || bus.wready)) begin
                  w_wr_next = W_RESP;
               end else begin
                  w_wr_next = W_ADDR;
               end
            end
            W_RESP: begin
               bus.bready = 1'b1;
               if (bus.bvalid) begin
                  bus.lsu_wr_done = 1'b1;
                  bus.lsu_wr_err  = resp_is_err(bus.bresp);
                  w_wr_next       = W_IDLE;
               end else begin
                  w_wr_next = W_RESP;
               end
            end
            default: w_wr_next = W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_aw_pend <= 1'b0;
         r_w_pend  <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_wr_strb <= 4'd0;
         r_wr_size <= 3'd0;
      end else if (w_wr_take) begin
         r_aw_pend <= 1'b1;
         r_w_pend  <= 1'b1;
         r_wr_addr <= bus.lsu_wr_addr;
         r_wr_data <= bus.lsu_wr_data;
         r_wr_strb <= bus.lsu_wr_strb;
         r_wr_size <= bus.lsu_wr_size;
      end else if (r_wr_state == W_ADDR) begin
         r_aw_pend <= r_aw_pend & ~bus.awready;
         r_w_pend  <= r_w_pend & ~bus.wready;
         r_wr_addr <= r_wr_addr;
         r_wr_data <= r_wr_data;
         r_wr_strb <= r_wr_strb;
         r_wr_size <= r_wr_size;
      end else begin
         r_aw_pend <= r_aw_pend;
         r_w_pend  <= r_w_pend;
         r_wr_addr <= r_wr_addr;
         r_wr_data <= r_wr_data;
         r_wr_strb <= r_wr_strb;
         r_wr_size <= r_wr_size;
      end
   end
endmodule

// File: tb/tb_ysyx_axi_arbiter.sv
// Directed bench for ysyx_axi_arbiter: the bench plays both core and AXI slave,
// driving inputs 1 time unit after the rising edge and checking 1 unit later.
module tb_ysyx_axi_arbiter;
   logic clock;
   logic reset;
   int   n_cmp;
   int   n_bad;

   ysyx_axi_arbiter_if #(.XLEN(32)) bus ();

   ysyx_axi_arbiter #(.XLEN(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_idle();
      bus.ifu_req_valid = 1'b0; bus.ifu_req_addr = 32'h0;
      bus.lsu_rd_valid = 1'b0;  bus.lsu_rd_addr = 32'h0; bus.lsu_rd_size = 3'd0;
      bus.lsu_wr_valid = 1'b0;  bus.lsu_wr_addr = 32'h0; bus.lsu_wr_data = 32'h0;
      bus.lsu_wr_strb = 4'h0;   bus.lsu_wr_size = 3'd0;
      bus.awready = 1'b0; bus.wready = 1'b0;
      bus.bvalid = 1'b0; bus.bid = 4'd0; bus.bresp = 2'b00;
      bus.arready = 1'b0;
      bus.rvalid = 1'b0; bus.rid = 4'd0; bus.rdata = 32'h0; bus.rresp = 2'b00; bus.rlast = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      cyc();
      bus.ifu_req_valid = 1'b1; bus.lsu_rd_valid = 1'b1; bus.lsu_wr_valid = 1'b1;
      bus.rvalid = 1'b1; bus.bvalid = 1'b1;
      #1;
      n_cmp++; if (bus.ifu_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ifu_ready: got %b want 0", bus.ifu_req_ready); end
      n_cmp++; if (bus.lsu_rd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_lsu_rd_ready: got %b want 0", bus.lsu_rd_ready); end
      n_cmp++; if (bus.lsu_wr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_lsu_wr_ready: got %b want 0", bus.lsu_wr_ready); end
      n_cmp++; if ({bus.arvalid, bus.awvalid, bus.wvalid} !== 3'b000) begin n_bad++; $display("FAIL rst_axi_valid: got %b want 000", {bus.arvalid, bus.awvalid, bus.wvalid}); end
      n_cmp++; if ({bus.rready, bus.bready} !== 2'b00) begin n_bad++; $display("FAIL rst_axi_ready: got %b want 00", {bus.rready, bus.bready}); end
      n_cmp++; if ({bus.ifu_rsp_valid, bus.lsu_rd_rsp_valid, bus.lsu_wr_done} !== 3'b000) begin n_bad++; $display("FAIL rst_rsp: got %b want 000", {bus.ifu_rsp_valid, bus.lsu_rd_rsp_valid, bus.lsu_wr_done}); end
      drive_idle();
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_ifu_read();
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0000;
      #1;
      n_cmp++; if ({bus.ifu_req_ready, bus.lsu_rd_ready} !== 2'b10) begin n_bad++; $display("FAIL ifu_grant: got %b want 10", {bus.ifu_req_ready, bus.lsu_rd_ready}); end
      cyc();
      bus.ifu_req_valid = 1'b0; bus.arready = 1'b1;
      #1;
      n_cmp++; if (bus.arvalid !== 1'b1) begin n_bad++; $display("FAIL ifu_arvalid: got %b want 1", bus.arvalid); end
      n_cmp++; if (bus.araddr !== 32'h8000_0000) begin n_bad++; $display("FAIL ifu_araddr: got %h want 80000000", bus.araddr); end
      n_cmp++; if ({bus.arid, bus.arsize, bus.arlen, bus.arburst} !== {4'd0, 3'd2, 8'd0, 2'b01}) begin n_bad++; $display("FAIL ifu_ar_fields: got %h want %h", {bus.arid, bus.arsize, bus.arlen, bus.arburst}, {4'd0, 3'd2, 8'd0, 2'b01}); end
      n_cmp++; if (bus.ifu_req_ready !== 1'b0) begin n_bad++; $display("FAIL ifu_grant_width: got %b want 0", bus.ifu_req_ready); end
      cyc();
      bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0000_0413; bus.rresp = 2'b00;
      #1;
      n_cmp++; if (bus.rready !== 1'b1) begin n_bad++; $display("FAIL ifu_rready: got %b want 1", bus.rready); end
      n_cmp++; if ({bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.lsu_rd_rsp_valid} !== 3'b100) begin n_bad++; $display("FAIL ifu_rsp: got %b want 100", {bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.lsu_rd_rsp_valid}); end
      n_cmp++; if (bus.ifu_rsp_data !== 32'h0000_0413) begin n_bad++; $display("FAIL ifu_rsp_data: got %h want 00000413", bus.ifu_rsp_data); end
      cyc();
      bus.rvalid = 1'b0;
      #1;
      n_cmp++; if ({bus.ifu_rsp_valid, bus.rready, bus.arvalid} !== 3'b000) begin n_bad++; $display("FAIL ifu_rsp_width: got %b want 000", {bus.ifu_rsp_valid, bus.rready, bus.arvalid}); end
   endtask

   task automatic test_round_robin();
      logic exp_lsu [3];
      exp_lsu = '{1'b0, 1'b1, 1'b0};
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      bus.lsu_rd_addr = 32'h8000_0100; bus.lsu_rd_size = 3'b001; bus.ifu_req_addr = 32'h8000_0200;
      for (int k = 0; k < 3; k++) begin
         bus.ifu_req_valid = 1'b1; bus.lsu_rd_valid = 1'b1;
         #1;
         n_cmp++; if ({bus.ifu_req_ready, bus.lsu_rd_ready} !== {~exp_lsu[k], exp_lsu[k]}) begin n_bad++; $display("FAIL rr_grant_%0d: got %b want %b", k, {bus.ifu_req_ready, bus.lsu_rd_ready}, {~exp_lsu[k], exp_lsu[k]}); end
         cyc();
         bus.arready = 1'b1;
         #1;
         n_cmp++; if ({bus.arid, bus.arsize} !== (exp_lsu[k] ? {4'd1, 3'd1} : {4'd0, 3'd2})) begin n_bad++; $display("FAIL rr_ar_%0d: got %h want %h", k, {bus.arid, bus.arsize}, (exp_lsu[k] ? {4'd1, 3'd1} : {4'd0, 3'd2})); end
         cyc();
         bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h1000_0000 + k;
         #1;
         n_cmp++; if ({bus.ifu_req_ready, bus.lsu_rd_ready} !== 2'b00) begin n_bad++; $display("FAIL rr_no_regrant_%0d: got %b want 00", k, {bus.ifu_req_ready, bus.lsu_rd_ready}); end
         n_cmp++; if ({bus.ifu_rsp_valid, bus.lsu_rd_rsp_valid} !== {~exp_lsu[k], exp_lsu[k]}) begin n_bad++; $display("FAIL rr_route_%0d: got %b want %b", k, {bus.ifu_rsp_valid, bus.lsu_rd_rsp_valid}, {~exp_lsu[k], exp_lsu[k]}); end
         bus.ifu_req_valid = 1'b0; bus.lsu_rd_valid = 1'b0;
         cyc();
         bus.rvalid = 1'b0;
      end
   endtask

   task automatic test_store();
      bus.lsu_wr_valid = 1'b1; bus.lsu_wr_addr = 32'h8000_1000; bus.lsu_wr_data = 32'hDEAD_BEEF;
      bus.lsu_wr_strb = 4'b0011; bus.lsu_wr_size = 3'd1;
      #1;
      n_cmp++; if ({bus.lsu_wr_ready, bus.awvalid} !== 2'b10) begin n_bad++; $display("FAIL st_accept: got %b want 10", {bus.lsu_wr_ready, bus.awvalid}); end
      cyc();
      bus.lsu_wr_valid = 1'b0; bus.awready = 1'b1; bus.wready = 1'b0;
      #1;
      n_cmp++; if ({bus.awvalid, bus.wvalid, bus.wlast, bus.lsu_wr_ready} !== 4'b1110) begin n_bad++; $display("FAIL st_aw_w_valid: got %b want 1110", {bus.awvalid, bus.wvalid, bus.wlast, bus.lsu_wr_ready}); end
      n_cmp++; if ({bus.awaddr, bus.wdata} !== {32'h8000_1000, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL st_addr_data: got %h want 80001000deadbeef", {bus.awaddr, bus.wdata}); end
      n_cmp++; if ({bus.wstrb, bus.awid, bus.awlen, bus.awburst, bus.awsize} !== {4'b0011, 4'd1, 8'd0, 2'b01, 3'd1}) begin n_bad++; $display("FAIL st_fields: got %h want %h", {bus.wstrb, bus.awid, bus.awlen, bus.awburst, bus.awsize}, {4'b0011, 4'd1, 8'd0, 2'b01, 3'd1}); end
      cyc();
      bus.awready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b010) begin n_bad++; $display("FAIL st_w_hold_%0d: got %b want 010", i, {bus.awvalid, bus.wvalid, bus.bready}); end
         cyc();
      end
      bus.wready = 1'b1;
      #1;
      n_cmp++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b010) begin n_bad++; $display("FAIL st_w_hs: got %b want 010", {bus.awvalid, bus.wvalid, bus.bready}); end
      cyc();
      bus.wready = 1'b0;
      #1;
      n_cmp++; if ({bus.wvalid, bus.bready, bus.lsu_wr_done} !== 3'b010) begin n_bad++; $display("FAIL st_wait_b: got %b want 010", {bus.wvalid, bus.bready, bus.lsu_wr_done}); end
      cyc();
      bus.bvalid = 1'b1; bus.bresp = 2'b00;
      #1;
      n_cmp++; if ({bus.lsu_wr_done, bus.lsu_wr_err} !== 2'b10) begin n_bad++; $display("FAIL st_done: got %b want 10", {bus.lsu_wr_done, bus.lsu_wr_err}); end
      cyc();
      bus.bvalid = 1'b0;
      #1;
      n_cmp++; if ({bus.lsu_wr_done, bus.bready, bus.awvalid} !== 3'b000) begin n_bad++; $display("FAIL st_done_width: got %b want 000", {bus.lsu_wr_done, bus.bready, bus.awvalid}); end
   endtask

   task automatic test_arready_stall();
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0040;
      #1;
      n_cmp++; if (bus.ifu_req_ready !== 1'b1) begin n_bad++; $display("FAIL stall_grant: got %b want 1", bus.ifu_req_ready); end
      cyc();
      bus.ifu_req_valid = 1'b0; bus.lsu_rd_valid = 1'b1; bus.lsu_rd_addr = 32'h8000_0050; bus.arready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h8000_0040}) begin n_bad++; $display("FAIL stall_ar_%0d: got %h want 180000040", i, {bus.arvalid, bus.araddr}); end
         n_cmp++; if (bus.lsu_rd_ready !== 1'b0) begin n_bad++; $display("FAIL stall_no_grant_%0d: got %b want 0", i, bus.lsu_rd_ready); end
         cyc();
      end
      bus.arready = 1'b1;
      #1;
      n_cmp++; if ({bus.arvalid, bus.arid} !== {1'b1, 4'd0}) begin n_bad++; $display("FAIL stall_ar_hs: got %h want 10", {bus.arvalid, bus.arid}); end
      cyc();
      bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0000_1234;
      #1;
      n_cmp++; if ({bus.ifu_rsp_valid, bus.lsu_rd_rsp_valid, bus.lsu_rd_ready} !== 3'b100) begin n_bad++; $display("FAIL stall_rsp: got %b want 100", {bus.ifu_rsp_valid, bus.lsu_rd_rsp_valid, bus.lsu_rd_ready}); end
      bus.lsu_rd_valid = 1'b0;
      cyc();
      bus.rvalid = 1'b0;
   endtask

   task automatic test_overlap_err();
      bus.lsu_rd_valid = 1'b1; bus.lsu_rd_addr = 32'h8000_2000; bus.lsu_rd_size = 3'd0;
      bus.lsu_wr_valid = 1'b1; bus.lsu_wr_addr = 32'h8000_3000; bus.lsu_wr_data = 32'h0000_0055;
      bus.lsu_wr_strb = 4'b0001; bus.lsu_wr_size = 3'd0;
      #1;
      n_cmp++; if ({bus.lsu_rd_ready, bus.lsu_wr_ready, bus.ifu_req_ready} !== 3'b110) begin n_bad++; $display("FAIL ovl_accept: got %b want 110", {bus.lsu_rd_ready, bus.lsu_wr_ready, bus.ifu_req_ready}); end
      cyc();
      bus.lsu_rd_valid = 1'b0; bus.lsu_wr_valid = 1'b0;
      bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
      #1;
      n_cmp++; if ({bus.arvalid, bus.awvalid, bus.wvalid} !== 3'b111) begin n_bad++; $display("FAIL ovl_valids: got %b want 111", {bus.arvalid, bus.awvalid, bus.wvalid}); end
      n_cmp++; if ({bus.arid, bus.arsize, bus.araddr} !== {4'd1, 3'd0, 32'h8000_2000}) begin n_bad++; $display("FAIL ovl_ar: got %h want %h", {bus.arid, bus.arsize, bus.araddr}, {4'd1, 3'd0, 32'h8000_2000}); end
      cyc();
      bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
      bus.rvalid = 1'b1; bus.rresp = 2'b10; bus.rdata = 32'h0000_0BAD;
      #1;
      n_cmp++; if ({bus.lsu_rd_rsp_valid, bus.lsu_rd_rsp_err, bus.ifu_rsp_valid} !== 3'b110) begin n_bad++; $display("FAIL ovl_rd_err: got %b want 110", {bus.lsu_rd_rsp_valid, bus.lsu_rd_rsp_err, bus.ifu_rsp_valid}); end
      n_cmp++; if (bus.lsu_rd_rsp_data !== 32'h0000_0BAD) begin n_bad++; $display("FAIL ovl_rd_data: got %h want 00000bad", bus.lsu_rd_rsp_data); end
      n_cmp++; if ({bus.bready, bus.awvalid, bus.wvalid} !== 3'b100) begin n_bad++; $display("FAIL ovl_wr_resp_wait: got %b want 100", {bus.bready, bus.awvalid, bus.wvalid}); end
      cyc();
      bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.bvalid = 1'b1; bus.bresp = 2'b00;
      #1;
      n_cmp++; if ({bus.lsu_wr_done, bus.lsu_wr_err, bus.lsu_rd_rsp_valid} !== 3'b100) begin n_bad++; $display("FAIL ovl_wr_done: got %b want 100", {bus.lsu_wr_done, bus.lsu_wr_err, bus.lsu_rd_rsp_valid}); end
      cyc();
      bus.bvalid = 1'b0;
      #1;
      n_cmp++; if (bus.lsu_wr_done !== 1'b0) begin n_bad++; $display("FAIL ovl_done_width: got %b want 0", bus.lsu_wr_done); end
   endtask

   task automatic test_reset_mid();
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0080;
      bus.lsu_wr_valid = 1'b1; bus.lsu_wr_addr = 32'h8000_4000;
      cyc();
      bus.ifu_req_valid = 1'b0; bus.lsu_wr_valid = 1'b0; bus.arready = 1'b1;
      cyc();
      bus.arready = 1'b0; reset = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h0000_0777;
      #1;
      n_cmp++; if ({bus.ifu_rsp_valid, bus.rready, bus.awvalid, bus.wvalid} !== 4'b0000) begin n_bad++; $display("FAIL rmid_quiet: got %b want 0000", {bus.ifu_rsp_valid, bus.rready, bus.awvalid, bus.wvalid}); end
      cyc();
      reset = 1'b0; bus.rvalid = 1'b0;
      #1;
      n_cmp++; if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b00000) begin n_bad++; $display("FAIL rmid_after: got %b want 00000", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}); end
      n_cmp++; if ({bus.ifu_rsp_valid, bus.lsu_wr_done} !== 2'b00) begin n_bad++; $display("FAIL rmid_no_rsp: got %b want 00", {bus.ifu_rsp_valid, bus.lsu_wr_done}); end
      bus.ifu_req_valid = 1'b1; bus.lsu_rd_valid = 1'b1;
      #1;
      n_cmp++; if ({bus.ifu_req_ready, bus.lsu_rd_ready} !== 2'b10) begin n_bad++; $display("FAIL rmid_tie: got %b want 10", {bus.ifu_req_ready, bus.lsu_rd_ready}); end
      cyc();
      drive_idle();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      drive_idle();
      test_reset();
      test_ifu_read();
      test_round_robin();
      test_store();
      test_arready_stall();
      test_overlap_err();
      test_reset_mid();
      cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ysyx_axi_arbiter.md
YSYX_AXI_ARBITER -- requirements
Module: ysyx_axi_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, setting the address and data width.
REQ-002 The block SHALL have port clock, input, 1, system clock.
REQ-003 The block SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-004 The block SHALL have ifu_req_valid/ifu_req_addr, input, 1/XLEN, instruction fetch read request.
REQ-005 The block SHALL have ifu_req_ready, output, 1, one-cycle grant pulse to IFU.
REQ-006 The block SHALL have ifu_rsp_valid/ifu_rsp_data/ifu_rsp_err, output, 1/XLEN/1, IFU read response.
REQ-007 The block SHALL have lsu_rd_valid/lsu_rd_addr/lsu_rd_size, input, 1/XLEN/3, LSU load request.
REQ-008 The block SHALL have lsu_rd_ready, output, 1, one-cycle grant pulse to the LSU load port.
REQ-009 The block SHALL have lsu_rd_rsp_valid/lsu_rd_rsp_data/lsu_rd_rsp_err, output, 1/XLEN/1, LSU load response.
REQ-010 The block SHALL have lsu_wr_valid/lsu_wr_addr/lsu_wr_data/lsu_wr_strb/lsu_wr_size, input, 1/XLEN/XLEN/4/3, LSU store request.
REQ-011 The block SHALL have lsu_wr_ready/lsu_wr_done/lsu_wr_err, output, 1/1/1, store accept pulse and completion pulse.
REQ-012 The block SHALL have AXI4 master AW (awvalid,awready,awid[4],awaddr,awlen[8],awsize[3],awburst[2]), W (wvalid,wready,wdata,wstrb[4],wlast), B (bvalid,bready,bid[4],bresp[2]), AR (arvalid,arready,arid,araddr,arlen,arsize,arburst), R (rvalid,rready,rid,rdata,rresp,rlast) ports, with directions per AXI4 master.

Function
REQ-013 The read FSM SHALL have states R_IDLE, R_ADDR, R_DATA; the write FSM SHALL have states W_IDLE, W_ADDR, W_RESP; the two SHALL run independently and concurrently.
REQ-014 In R_IDLE with any read valid, the block SHALL grant one requester, pulse its *_ready that cycle, latch addr/size/id, and enter R_ADDR next cycle.
REQ-015 On simultaneous IFU and LSU read valid, the grant SHALL go to the requester not granted last (round-robin); a single valid requester SHALL always be granted.
REQ-016 In R_ADDR the block SHALL hold arvalid=1 with latched araddr (unmodified), arlen=0, arburst=2'b01, arsize=3'b010 for IFU or lsu_rd_size for LSU, arid=0 for IFU or 1 for LSU, stable until arready, then enter R_DATA.
REQ-017 In R_DATA the block SHALL drive rready=1; on rvalid it SHALL assert the granted requester's rsp_valid combinationally that same cycle with rsp_data=rdata, rsp_err=(rresp!=2'b00), and return to R_IDLE next cycle.
REQ-018 Response routing SHALL use the latched grant; rid SHALL be ignored.
REQ-019 The minimum request-to-response latency SHALL be 2 cycles after the grant cycle (zero-wait slave); only one read SHALL be outstanding.
REQ-020 In W_IDLE with lsu_wr_valid, the block SHALL pulse lsu_wr_ready, latch the store, and enter W_ADDR.
REQ-021 In W_ADDR the block SHALL assert awvalid and wvalid together, awlen=0, awburst=2'b01, wlast=1, awid=1, and deassert each independently upon its own handshake; it SHALL enter W_RESP once both have completed, in either order or the same cycle.
REQ-022 In W_RESP the block SHALL drive bready=1; on bvalid it SHALL pulse lsu_wr_done with lsu_wr_err=(bresp!=2'b00) and return to W_IDLE.
REQ-023 A new read request SHALL NOT be granted in the cycle a response completes; re-grant SHALL occur from R_IDLE.
REQ-024 All grant, response and done pulses SHALL be exactly one cycle wide.

Reset
REQ-025 While reset is high, both FSMs SHALL go to IDLE, all valid/ready/pulse outputs SHALL be 0, and the round-robin pointer SHALL make IFU win the first tie.
REQ-026 A reset asserted mid-transaction SHALL drop the outstanding transaction without issuing a response.

Structure
REQ-027 The read/write state enums, AXI burst/resp encodings and requester ID constants SHALL be defined in shared package ysyx_bus_pkg.
REQ-028 Round-robin selection SHALL be implemented in sub-module ysyx_rr_arb2 (two requests, a last-grant register, and a one-hot grant output).

Verification
REQ-029 An IFU read of 0x80000000 with a zero-wait slave SHALL produce arid=0, arsize=2, and ifu_rsp_valid 2 cycles after grant with data 0x00000413.
REQ-030 IFU and LSU reads in the same cycle for 3 consecutive rounds SHALL produce the grant order IFU, LSU, IFU.
REQ-031 An LSU store to 0x80001000 with wstrb=4'b0011 and wready delayed 3 cycles after awready SHALL hold wvalid until wready, then produce one lsu_wr_done pulse.
REQ-032 Arready held low for 5 cycles SHALL keep araddr/arvalid stable and produce no grant to the other requester.
REQ-033 rresp=2'b10 on an LSU load SHALL produce lsu_rd_rsp_err=1, and a store overlapping an in-flight read SHALL have both complete.
REQ-034 Reset asserted in R_DATA SHALL produce no response pulse and return all outputs to their reset values on the next cycle.
